cru_cascade: RTL
================

Name: cru_cascade

Overview:
Parametrised clock/reset unit for the radio datapath on the 240 MHz PLL clock. It produces one synchronised, stretched, active-high reset for downstream cores. Reset release is gated on PLL lock. It also produces N_EN cascaded, phase-aligned one-cycle clock-enable pulses, with division ratios set per stage. The default configuration gives 48 MHz, 960 kHz and 32 kHz enables for radio_core en1/en_b/en_a.

Parameters:
N_EN, 3, number of cascaded enable stages (1..8)
DIV, '{5,50,30}, int unsigned array [N_EN]; stage k divides stage k-1 ticks (stage 0 divides clk); each entry >= 1
RST_STRETCH, 16, clk cycles reset_out stays high after lock is seen (>= 1)
SYNC_STAGES, 2, synchroniser depth for reset_n release and pll_locked (>= 2)

Ports:
clk  input  1  240 MHz PLL clock; the only clock
reset_n  input  1  asynchronous active-low external reset (asserted from KEY)
pll_locked  input  1  PLL lock indicator, asynchronous to clk
sync_clr  input  1  synchronous realign of all dividers; active high
reset_out  output  1  synchronised active-high reset for downstream logic
en  output  N_EN  en[k] = stage-k clock-enable pulse, one clk wide

Behaviour:
- Reset assertion: reset_n low asynchronously clears all flops.
  - reset_out=1, en='0, all counters 0, FSM=SYNC.
- Reset release: asynchronous assert, synchronous deassert through a SYNC_STAGES flop chain.
- pll_locked is synchronised through SYNC_STAGES flops to give locked_s.
- FSM states and transitions:
  - SYNC: waits for the reset_n synchroniser output to go high, then goes to WAIT_LOCK.
  - WAIT_LOCK: goes to STRETCH when locked_s=1.
  - STRETCH: counts RST_STRETCH cycles, then goes to RUN. If locked_s=0 in any STRETCH cycle, the count clears and the FSM returns to WAIT_LOCK.
  - RUN: terminal state. Without the optional feature, lock loss in RUN is ignored.
- reset_out is registered; it is 1 in SYNC, WAIT_LOCK and STRETCH, and 0 in RUN.
- Timing reference: t=0 is the first cycle with reset_out=0.
- Dividers (active only in RUN; counters and en held at 0 otherwise):
  - Stage 0 counter c0 counts 0..DIV[0]-1, advancing every cycle.
  - Stage k>0 counter c_k advances only when tick_{k-1} is true.
  - tick_0 = (c0==DIV[0]-1).
  - tick_k = tick_{k-1} && (c_k==DIV[k]-1).
  - Counters wrap to 0 on their tick.
  - en[k] is the registered tick_k.
  - Let P_k = DIV[0]*...*DIV[k]. Then en[k] is high exactly at t = m*P_k for m >= 1.
  - Every en[k] pulse coincides with an en[j] pulse for all j<k.
- DIV[k]=1: stage k has no counter, and en[k] follows en[k-1] exactly.
- Counter width is max(1, $clog2(DIV[k])).
- Elaboration fails (fatal) if any DIV entry is 0, N_EN is out of range, or SYNC_STAGES<2.
- sync_clr (honoured only in RUN):
  - If sync_clr=1 in cycle s, all counters and en are 0 in cycle s+1.
  - Cycle s+1 then acts as a new t=0, so en[k] next pulses at s+1+P_k.
  - If sync_clr coincides with a terminal count, clear wins and no pulse is emitted.
  - If sync_clr is held high, en stays 0.
- reset_n low mid-operation, including mid-STRETCH or on a pulse cycle: immediate return to the reset values.

Optional Feature:
Macro CRU_LOCK_MONITOR_EN.
- Defined:
  - Adds output lol_sticky (1 bit) and input lol_clr (1 bit).
  - In RUN, locked_s=0 moves the FSM to WAIT_LOCK, so reset_out=1 from the next cycle and dividers clear.
  - The same event sets lol_sticky=1.
  - lol_clr=1 clears lol_sticky synchronously; a set on the same cycle wins.
  - lol_sticky resets to 0.
- Undefined: the ports are absent, and lock loss in RUN has no effect.

Decomposition:
- Package cru_pkg holds:
  - the FSM state enum (SYNC, WAIT_LOCK, STRETCH, RUN);
  - function div_prod(DIV,k) returning P_k, used for checks and testbench timing;
  - function cnt_width(d) returning max(1,$clog2(d)).
- Sub-module cru_div_stage: one counter stage.
  - Ports: clk, reset_n, run, clr, tick_in, tick_out.
  - Parameter DIV.
  - Instanced N_EN times by generate.

Test Plan:
- Defaults, pll_locked=1, release reset_n: reset_out falls SYNC_STAGES+1(WAIT_LOCK)+16 cycles (±1 for lock synchroniser) after release. en[0] period 5, en[1] period 250, en[2] period 7500, first pulses at t=5, 250, 7500, all coincident.
- pll_locked held 0 for 1000 cycles after reset release: reset_out stays 1 and en stays 0. Drop lock at STRETCH count 10: the count restarts, and reset_out falls 16 cycles after lock returns.
- sync_clr pulsed at t=1234: en all 0 at t=1235. Next en[0] at 1240, en[1] at 1485. The clear coinciding with the en[0] terminal at t=1249 suppresses that pulse.
- DIV='{1,4,1}, N_EN=3: en[0] high every cycle, en[1] and en[2] identical with period 4. An elaboration-time check rejects DIV='{0,...}.
- reset_n asserted mid-run on an en[2] pulse cycle: reset_out=1 and en=0 without waiting for clk. Recovery timing is the same as in the first scenario.
- CRU_LOCK_MONITOR_EN defined, lock dropped in RUN: reset_out=1 and lol_sticky=1 once the drop passes the lock synchroniser. lol_sticky holds after lock returns and clears one cycle after lol_clr.

Source files
------------

// File: rtl/cru_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cru_pkg
//  Description : Shared types and helper functions for the cru_cascade
//                clock/reset unit: FSM state encoding, divider-ratio vector
//                type, cascaded period product and counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cru_pkg;

   // Largest supported number of cascaded enable stages.
   localparam int unsigned MAX_EN = 8;

   // Fixed-size ratio vector so helpers can take any configuration.
   // Unused trailing entries are expected to be 1.
   typedef int unsigned div_vec_t [MAX_EN];

   typedef enum logic [1:0] {
      SYNC      = 2'd0,
      WAIT_LOCK = 2'd1,
      STRETCH   = 2'd2,
      RUN       = 2'd3
   } cru_state_e;

   // P_k = d[0] * d[1] * ... * d[k]: period of enable k in clk cycles.
   function automatic int unsigned div_prod(input div_vec_t d, input int unsigned k);
      int unsigned p;
      p = 1;
      for (int i = 0; i < MAX_EN; i++) begin
         if (i <= int'(k)) p = p * d[i[2:0]];
      end
      return p;
   endfunction

   // Counter width for a modulo-d counter, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned d);
      return (d < 2) ? 1 : $clog2(d);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cru_div_stage.sv
`default_nettype none
// ============================================================================
//  Module      : cru_div_stage
//  Description : One stage of the enable divider cascade. Counts incoming
//                ticks modulo DIV and passes a tick on at terminal count.
//                DIV = 1 degenerates to a wire (no counter).
//  Ports       : clk       - clock
//                reset_n   - asynchronous active-low reset
//                run       - counter may advance; low holds counter at 0
//                clr       - synchronous realign, counter to 0
//                tick_in   - tick from the previous stage (1 for stage 0)
//                tick_out  - tick_in qualified by terminal count
//  Revision    : 1.0 - initial release
// ============================================================================
module cru_div_stage
   import cru_pkg::*;
#(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   input  logic clr,
   input  logic tick_in,
   output logic tick_out
);

   if (DIV == 1) begin : g_pass
      // Pure pass-through; the control inputs have no work to do here.
      logic w_unused;
      assign w_unused = &{1'b0, clk, reset_n, run, clr};
      assign tick_out = tick_in;
   end else begin : g_cnt
      localparam int unsigned W = cnt_width(DIV);
      localparam logic [W-1:0] LAST = W'(DIV - 1);

      logic [W-1:0] cnt_q;
      logic         w_last;

      assign w_last   = (cnt_q == LAST);
      assign tick_out = tick_in && w_last;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q <= '0;
         end else if (!run || clr) begin
            cnt_q <= '0;
         end else if (tick_in) begin
            cnt_q <= w_last ? '0 : cnt_q + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/cru_cascade.sv
`default_nettype none
// ============================================================================
//  Module      : cru_cascade
//  Description : Clock/reset unit for the 240 MHz radio datapath. Produces a
//                synchronised, lock-gated, stretched active-high reset and
//                N_EN cascaded, phase-aligned one-cycle clock enables.
//  Ports       : clk        - 240 MHz PLL clock
//                reset_n    - asynchronous active-low external reset
//                pll_locked - PLL lock, asynchronous to clk
//                sync_clr   - synchronous realign of all dividers (RUN only)
//                reset_out  - registered active-high downstream reset
//                en[N_EN]   - stage enable pulses, one clk wide
//                lol_clr    - clears lol_sticky    (CRU_LOCK_MONITOR_EN)
//                lol_sticky - loss-of-lock flag     (CRU_LOCK_MONITOR_EN)
//  Options     : CRU_LOCK_MONITOR_EN - lock loss in RUN returns the unit to
//                WAIT_LOCK and sets a sticky loss-of-lock flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module cru_cascade
   import cru_pkg::*;
#(
   parameter int unsigned N_EN             = 3,
   parameter int unsigned DIV [N_EN]       = '{5, 50, 30},
   parameter int unsigned RST_STRETCH      = 16,
   parameter int unsigned SYNC_STAGES      = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            pll_locked,
   input  logic            sync_clr,
`ifdef CRU_LOCK_MONITOR_EN
   input  logic            lol_clr,
   output logic            lol_sticky,
`endif
   output logic            reset_out,
   output logic [N_EN-1:0] en
);

   // ---------------------------------------------------------------------
   // Elaboration-time configuration checks
   // ---------------------------------------------------------------------
   if (N_EN < 1 || N_EN > MAX_EN) begin : g_bad_n_en
      $fatal(1, "cru_cascade: N_EN=%0d out of range 1..%0d", N_EN, MAX_EN);
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "cru_cascade: SYNC_STAGES=%0d must be >= 2", SYNC_STAGES);
   end
   if (RST_STRETCH < 1) begin : g_bad_stretch
      $fatal(1, "cru_cascade: RST_STRETCH must be >= 1");
   end

   localparam int unsigned SW = cnt_width(RST_STRETCH);
   localparam logic [SW-1:0] STRETCH_LAST = SW'(RST_STRETCH - 1);

   // ---------------------------------------------------------------------
   // Synchronisers: reset release (async assert, sync deassert) and lock
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] rst_sync_q;
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic                   w_rst_s;
   logic                   w_locked_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_q  <= '0;
         lock_sync_q <= '0;
      end else begin
         rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign w_rst_s    = rst_sync_q[SYNC_STAGES-1];
   assign w_locked_s = lock_sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------
   // Reset sequencing FSM with registered reset_out
   // ---------------------------------------------------------------------
   cru_state_e    state_q;
   logic [SW-1:0] stretch_q;
   logic          reset_out_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SYNC;
         stretch_q   <= '0;
         reset_out_q <= 1'b1;
      end else begin
         case (state_q)
            SYNC: begin
               if (w_rst_s) state_q <= WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (w_locked_s) begin
                  state_q   <= STRETCH;
                  stretch_q <= '0;
               end
            end
            STRETCH: begin
               // Any lock dropout restarts the whole stretch window.
               if (!w_locked_s) begin
                  state_q   <= WAIT_LOCK;
                  stretch_q <= '0;
               end else if (stretch_q == STRETCH_LAST) begin
                  state_q     <= RUN;
                  stretch_q   <= '0;
                  reset_out_q <= 1'b0;
               end else begin
                  stretch_q <= stretch_q + 1'b1;
               end
            end
            RUN: begin
`ifdef CRU_LOCK_MONITOR_EN
               if (!w_locked_s) begin
                  state_q     <= WAIT_LOCK;
                  reset_out_q <= 1'b1;
               end
`endif
            end
            default: begin
               state_q     <= SYNC;
               reset_out_q <= 1'b1;
            end
         endcase
      end
   end

   assign reset_out = reset_out_q;

   // Dividers run only in RUN; with the lock monitor, a lock loss stops them
   // on the same edge the FSM leaves RUN so no stray pulse escapes.
   logic w_run;
`ifdef CRU_LOCK_MONITOR_EN
   assign w_run = (state_q == RUN) && w_locked_s;

   logic lol_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lol_q <= 1'b0;
      end else if ((state_q == RUN) && !w_locked_s) begin
         lol_q <= 1'b1;
      end else if (lol_clr) begin
         lol_q <= 1'b0;
      end
   end
   assign lol_sticky = lol_q;
`else
   assign w_run = (state_q == RUN);
`endif

   // ---------------------------------------------------------------------
   // Divider cascade: tick_chain[k] feeds stage k, tick_chain[k+1] = tick_k
   // ---------------------------------------------------------------------
   logic [N_EN:0]   tick_chain;
   logic [N_EN-1:0] en_q;
   logic [N_EN-1:0] en_d;

   assign tick_chain[0] = 1'b1;

   for (genvar k = 0; k < N_EN; k++) begin : g_stage
      if (DIV[k] == 0) begin : g_bad_div
         $fatal(1, "cru_cascade: DIV[%0d] must be >= 1", k);
      end
      cru_div_stage #(
         .DIV (DIV[k])
      ) u_stage (
         .clk      (clk),
         .reset_n  (reset_n),
         .run      (w_run),
         .clr      (sync_clr),
         .tick_in  (tick_chain[k]),
         .tick_out (tick_chain[k+1])
      );
   end

   // A clear wins over a coincident terminal count.
   assign en_d = (w_run && !sync_clr) ? tick_chain[N_EN:1] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_q <= '0;
      end else begin
         en_q <= en_d;
      end
   end

   assign en = en_q;

endmodule
`default_nettype wire
